fetcher: RTL
============

Name: fetcher

Overview:
- Instruction fetch stage; the transmitting end of the fetcher_valid/decoder_ready handshake consumed by the decoder.
- Reads aligned 32-bit words from instruction memory and realigns mixed 16/32-bit (RV32C) instructions, including 32-bit instructions that straddle a word boundary.
- Presents one instruction at a time with its pc.
- Accepts pc redirects from the executor for jumps, branches and traps.

Parameters:
- RESET_PC, 32'h0000_0000, pc loaded on reset; must be 2-byte aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- decoder_ready  in  1  decoder can accept an instruction this cycle.
- fetcher_valid  out  1  instr/fetcher_pc hold a valid instruction.
- instr  out  32  instruction; compressed instructions are zero-extended as {16'b0, half}.
- fetcher_pc  out  32  address of instr.
- redirect  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  new pc.
- mem_valid  out  1  memory read request.
- mem_addr  out  32  word address of the request; bits [1:0] are always 0.
- mem_ready  in  1  mem_rdata is valid this cycle; completes the request.
- mem_rdata  in  32  read data.
- fetch_error  out  1  redirect to an odd address; sticky.

Behaviour:
- Reset values: fetcher_valid=0, instr=0, fetcher_pc=0, mem_valid=0, mem_addr=0, fetch_error=0, pc=RESET_PC, word buffer invalid, state=FETCH.
- State FETCH:
  - mem_valid=1, mem_addr={pc[31:2],2'b00}.
  - Address is held stable until the mem_ready cycle; the word is captured on that edge.
  - Next state is PRESENT if the instruction is resident, else SPILL.
- Instruction extraction:
  - half = pc[1] ? word[31:16] : word[15:0].
  - half[1:0]!=2'b11 → compressed, instr={16'b0,half}, length 2.
  - Otherwise 32-bit, length 4. With pc[1]=0 it is resident as word[31:0]. With pc[1]=1 it straddles.
- State SPILL:
  - Saves word[31:16] as the low half.
  - Requests the word at mem_addr+4; instr={next[15:0], saved_half}.
  - The new word becomes the buffered word.
- State PRESENT:
  - fetcher_valid=1; instr and fetcher_pc are registered and held stable while decoder_ready=0.
  - No memory request is issued while in PRESENT.
- Transfer:
  - A transfer occurs on a cycle with fetcher_valid && decoder_ready.
  - On transfer, pc += length.
  - If the next instruction is fully resident (same word, pc[1] becomes 1, and that half is compressed), fetcher_valid stays 1 and instr/fetcher_pc update on the same edge (zero bubble).
  - Else fetcher_valid drops to 0 and the state goes to FETCH or SPILL.
  - A straddle continues from the buffered word's upper half without re-reading it.
- Latency:
  - mem_valid is high the first cycle after reset deasserts.
  - fetcher_valid rises the cycle after the mem_ready edge that completes the instruction.
- Redirect (priority over everything except reset):
  - Next cycle: fetcher_valid=0, buffer invalidated, pc=redirect_pc, state=FETCH.
  - Any pending request is dropped: mem_valid may deassert before mem_ready (memory tolerates withdrawal), and mem_rdata returned on the redirect cycle is discarded.
  - Redirect on the same cycle as a transfer: the transfer counts as complete, and the redirect decides the next pc.
- Odd redirect_pc[0]:
  - State ERROR: fetch_error=1, mem_valid=0, fetcher_valid=0.
  - Exits only on reset or on a later aligned redirect, which clears fetch_error and enters FETCH.
- Reset mid-request or mid-present: abandons everything immediately and returns to the reset values.
- pc arithmetic: 32-bit wrap; 0xFFFF_FFFE + 2 → 0.

Decomposition:
- fetch_pkg: state enum {FETCH, SPILL, PRESENT, ERROR}, INSTR_LEN_C=2 and INSTR_LEN_W=4 constants, and an is_compressed(half) function (quadrant != 2'b11) shared with the decoder.
- One combinational sub-module, fetch_align: inputs are word, saved half, pc[1] and a spill flag; outputs are instr, length and resident.

Test Plan:
- Aligned 32-bit: RESET_PC=0, mem[0]=0x00000013, mem_ready immediate → mem_addr=0; then fetcher_valid=1, instr=0x00000013, fetcher_pc=0; after transfer, mem_addr=4.
- Compressed pair: mem[0]=0x00014501 → instr 0x00004501 at pc 0, then 0x00000001 at pc 2 with no bubble; exactly one memory read.
- Straddle: mem[0]=0x00930001, mem[4]=0x00010000 → 0x00000001 at pc 0, 0x00000093 at pc 2 (reads 0 then 4), 0x00000001 at pc 6 with no re-read of address 4.
- Backpressure plus wait states: mem_ready delayed 3 cycles, then decoder_ready=0 for 5 cycles → mem_addr stable while waiting; instr/fetcher_pc/fetcher_valid stable; mem_valid=0 during the stall.
- Redirect: redirect=1, redirect_pc=0x100, while mem_valid=1 and mem_ready=0 → next cycle fetcher_valid=0, mem_addr=0x100. Repeat coincident with a transfer → the transfer counts and the next fetcher_pc is 0x100.
- Misaligned: redirect_pc=0x101 → fetch_error=1, mem_valid=0 for 10+ cycles. Then redirect_pc=0x200 → fetch_error=0 and mem_addr=0x200 next cycle. A reset in the ERROR state restores RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, instruction lengths and
// the RV32C quadrant test that the decoder uses as well.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH   = 2'd0;
  localparam fetch_state_t SPILL   = 2'd1;
  localparam fetch_state_t PRESENT = 2'd2;
  localparam fetch_state_t ERROR   = 2'd3;

  localparam logic [2:0] INSTR_LEN_C = 3'd2;
  localparam logic [2:0] INSTR_LEN_W = 3'd4;

  // Only the two quadrant bits of a halfword decide whether it is compressed.
  function automatic logic is_compressed(input logic [1:0] quadrant);
    return quadrant != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Realigns one instruction out of a fetched word. When spill_i is set the
// word is the second half of a straddling 32-bit instruction whose low half
// was saved from the previous word.
module fetch_align
  import fetch_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] savedHalf_i,
  input  logic        pcHalf_i,
  input  logic        spill_i,
  output logic [31:0] instr_o,
  output logic [2:0]  length_o,
  output logic        resident_o
);

  logic [15:0] half;

  // Pick the addressed halfword and decide length and whether it is complete.
  always_comb begin
    half       = pcHalf_i ? word_i[31:16] : word_i[15:0];
    instr_o    = word_i;
    length_o   = INSTR_LEN_W;
    resident_o = !pcHalf_i;
    if (spill_i) begin
      instr_o    = {word_i[15:0], savedHalf_i};
      resident_o = 1'b1;
    end else if (is_compressed(half[1:0])) begin
      instr_o    = {16'b0, half};
      length_o   = INSTR_LEN_C;
      resident_o = 1'b1;
    end
  end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage. Reads aligned words, realigns mixed 16/32-bit
// instructions (including word-straddling ones) and hands them one at a time
// to the decoder over a valid/ready handshake. Redirects restart fetch.
module fetcher
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        decoder_ready,
  output logic        fetcher_valid,
  output logic [31:0] instr,
  output logic [31:0] fetcher_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        fetch_error
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  word_q, word_d;
  logic [15:0]  savedHalf_q, savedHalf_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  fetcherPc_q, fetcherPc_d;
  logic [2:0]   len_q, len_d;
  logic         fetchError_q, fetchError_d;

  logic [31:0]  pcNext;
  logic [31:0]  wordAddr;
  logic         transfer;
  logic [31:0]  alignWord;
  logic         alignPcHalf;
  logic         alignSpill;
  logic [31:0]  alignInstr;
  logic [2:0]   alignLen;
  logic         alignResident;

  assign pcNext   = pc_q + {29'b0, len_q};
  assign wordAddr = {pc_q[31:2], 2'b00};
  assign transfer = valid_q && decoder_ready;

  assign mem_valid     = !reset && ((state_q == FETCH) || (state_q == SPILL));
  assign mem_addr      = (state_q == SPILL) ? wordAddr + 32'd4 : wordAddr;
  assign fetcher_valid = valid_q;
  assign instr         = instr_q;
  assign fetcher_pc    = fetcherPc_q;
  assign fetch_error   = fetchError_q;

  // In PRESENT the aligner looks ahead into the buffered word for the next
  // instruction; otherwise it works on the word arriving from memory.
  always_comb begin
    alignWord   = mem_rdata;
    alignPcHalf = pc_q[1];
    alignSpill  = (state_q == SPILL);
    if (state_q == PRESENT) begin
      alignWord   = word_q;
      alignPcHalf = pcNext[1];
    end
  end

  fetch_align u_align (
    .word_i      (alignWord),
    .savedHalf_i (savedHalf_q),
    .pcHalf_i    (alignPcHalf),
    .spill_i     (alignSpill),
    .instr_o     (alignInstr),
    .length_o    (alignLen),
    .resident_o  (alignResident)
  );

  // Next-state logic; a redirect overrides whatever the state would do.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    word_d       = word_q;
    savedHalf_d  = savedHalf_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    fetcherPc_d  = fetcherPc_q;
    len_d        = len_q;
    fetchError_d = fetchError_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          word_d = mem_rdata;
          if (alignResident) begin
            instr_d     = alignInstr;
            fetcherPc_d = pc_q;
            len_d       = alignLen;
            valid_d     = 1'b1;
            state_d     = PRESENT;
          end else begin
            savedHalf_d = mem_rdata[31:16];
            state_d     = SPILL;
          end
        end
      end
      SPILL: begin
        if (mem_ready) begin
          word_d      = mem_rdata;
          instr_d     = alignInstr;
          fetcherPc_d = pc_q;
          len_d       = alignLen;
          valid_d     = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (transfer) begin
          pc_d = pcNext;
          if (!pcNext[1]) begin
            valid_d = 1'b0;
            state_d = FETCH;
          end else if (alignResident) begin
            instr_d     = alignInstr;
            fetcherPc_d = pcNext;
            len_d       = alignLen;
          end else begin
            valid_d     = 1'b0;
            savedHalf_d = word_q[31:16];
            state_d     = SPILL;
          end
        end
      end
      ERROR: begin
      end
    endcase
    if (redirect) begin
      valid_d      = 1'b0;
      pc_d         = redirect_pc;
      fetchError_d = redirect_pc[0];
      state_d      = redirect_pc[0] ? ERROR : FETCH;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      word_q       <= 32'b0;
      savedHalf_q  <= 16'b0;
      valid_q      <= 1'b0;
      instr_q      <= 32'b0;
      fetcherPc_q  <= 32'b0;
      len_q        <= INSTR_LEN_W;
      fetchError_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      word_q       <= word_d;
      savedHalf_q  <= savedHalf_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      fetcherPc_q  <= fetcherPc_d;
      len_q        <= len_d;
      fetchError_q <= fetchError_d;
    end
  end

endmodule
